// File: rtl/usb_tx_sequencer.sv
// IN-transaction transmit sequencer: token accept, NAK/DATA1 decision, SYNC/PID/payload/EOP byte feed.
// Optional CRC16 trailer on DATA1 packets when the CRC16_EN macro is defined.
`timescale 1ns/1ps
module usb_tx_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h4C,
    parameter int          PKT_BYTES      = 64,
    parameter int          TURNAROUND_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_token_valid,
    input  logic [7:0] rx_pid,
    input  logic [6:0] rx_addr,
    input  logic       rx_error,
    input  logic       fifo_ready,
`ifdef CRC16_EN
    input  logic [7:0] fifo_head_byte,
`endif
    output logic       fifo_r_enable,
    output logic       tx_sel,
    output logic [7:0] tx_fsm_byte,
    output logic       tx_start,
    input  logic       tx_byte_req,
    output logic       tx_eop,
    input  logic       tx_done,
    output logic       is_txing
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_TURN      = 4'd1;
    localparam logic [3:0] ST_SYNC      = 4'd2;
    localparam logic [3:0] ST_PID       = 4'd3;
    localparam logic [3:0] ST_DATA      = 4'd4;
`ifdef CRC16_EN
    localparam logic [3:0] ST_CRC_LO    = 4'd5;
    localparam logic [3:0] ST_CRC_HI    = 4'd6;
`endif
    localparam logic [3:0] ST_EOP       = 4'd7;
    localparam logic [3:0] ST_WAIT_DONE = 4'd8;

    localparam logic [7:0]  PID_IN    = 8'h69;
    localparam logic [7:0]  PID_DATA1 = 8'h4B;
    localparam logic [7:0]  PID_NAK   = 8'h5A;
    localparam logic [7:0]  SYNC_BYTE = 8'h80;
    localparam logic [15:0] TURN_LAST = 16'(TURNAROUND_CYC - 1);
    localparam logic [7:0]  BYTE_LAST = 8'(PKT_BYTES - 1);

    logic [3:0]  state_q, state_d;
    logic [15:0] turn_cnt_q, turn_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic        data1_q, data1_d;
    logic        pop_q, pop_d;
    logic        accept;

`ifdef CRC16_EN
    logic [15:0] crc_q, crc_d;

    // Reflected form of x^16+x^15+x^2+1, data consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
        end
        return c;
    endfunction
`endif

    assign accept = rx_token_valid && !rx_error && (rx_addr == DEV_ADDR);

    always_comb begin
        state_d    = state_q;
        turn_cnt_d = turn_cnt_q;
        byte_cnt_d = byte_cnt_q;
        data1_d    = data1_q;
        pop_d      = 1'b0;
`ifdef CRC16_EN
        crc_d      = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = 16'd0;
                    data1_d    = (rx_pid == PID_IN) && fifo_ready;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    state_d = ST_SYNC;
                end else begin
                    turn_cnt_d = turn_cnt_q + 16'd1;
                end
            end
            ST_SYNC: begin
                if (tx_byte_req) state_d = ST_PID;
            end
            ST_PID: begin
                if (tx_byte_req) begin
                    if (data1_q) begin
                        state_d    = ST_DATA;
                        byte_cnt_d = 8'd0;
`ifdef CRC16_EN
                        crc_d      = 16'hFFFF;
`endif
                    end else begin
                        state_d = ST_EOP;
                    end
                end
            end
            ST_DATA: begin
                // The request acknowledges the FIFO head byte; pop it on the following cycle.
                if (tx_byte_req) begin
                    pop_d      = 1'b1;
                    byte_cnt_d = byte_cnt_q + 8'd1;
`ifdef CRC16_EN
                    crc_d      = crc16_byte(crc_q, fifo_head_byte);
                    if (byte_cnt_q == BYTE_LAST) state_d = ST_CRC_LO;
`else
                    if (byte_cnt_q == BYTE_LAST) state_d = ST_EOP;
`endif
                end
            end
`ifdef CRC16_EN
            ST_CRC_LO: begin
                if (tx_byte_req) state_d = ST_CRC_HI;
            end
            ST_CRC_HI: begin
                if (tx_byte_req) state_d = ST_EOP;
            end
`endif
            ST_EOP: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            turn_cnt_q <= 16'd0;
            byte_cnt_q <= 8'd0;
            data1_q    <= 1'b0;
            pop_q      <= 1'b0;
`ifdef CRC16_EN
            crc_q      <= 16'hFFFF;
`endif
        end else begin
            state_q    <= state_d;
            turn_cnt_q <= turn_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            data1_q    <= data1_d;
            pop_q      <= pop_d;
`ifdef CRC16_EN
            crc_q      <= crc_d;
`endif
        end
    end

    // Outputs decode registered state only, so an async reset clears them in the same cycle.
    always_comb begin
        tx_start      = (state_q == ST_TURN) && (turn_cnt_q == TURN_LAST);
        is_txing      = tx_start || ((state_q != ST_IDLE) && (state_q != ST_TURN));
        tx_eop        = (state_q == ST_EOP);
        tx_sel        = (state_q != ST_DATA);
        fifo_r_enable = pop_q;
        case (state_q)
            ST_PID:    tx_fsm_byte = data1_q ? PID_DATA1 : PID_NAK;
`ifdef CRC16_EN
            ST_CRC_LO: tx_fsm_byte = ~crc_q[7:0];
            ST_CRC_HI: tx_fsm_byte = ~crc_q[15:8];
`endif
            default:   tx_fsm_byte = SYNC_BYTE;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Self-checking bench for usb_tx_sequencer: transmitter/FIFO behavioural model, vector table,
// corner-case sequences and randomized tokens. Define CRC16_EN to exercise the CRC trailer.
`timescale 1ns/1ps
module tb_usb_tx_sequencer;

    localparam int PKT  = 64;
    localparam int TURN = 16;
    localparam int K_NONE = 0, K_NAK = 1, K_DATA1 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_token_valid, rx_error, fifo_ready, tx_byte_req, tx_done;
    logic [7:0] rx_pid;
    logic [6:0] rx_addr;
    logic       fifo_r_enable, tx_sel, tx_start, tx_eop, is_txing;
    logic [7:0] tx_fsm_byte;
    logic [7:0] fifo_head_byte;

    logic [7:0] fifo_mem [0:1023];
    int         fifo_head  = 0;
    int         pop_count  = 0;
    int         compared   = 0;
    int         mismatched = 0;
    int         txn_no     = 0;

    always #5 clk = ~clk;

    assign fifo_head_byte = fifo_mem[fifo_head % 1024];

    usb_tx_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .rx_token_valid (rx_token_valid),
        .rx_pid         (rx_pid),
        .rx_addr        (rx_addr),
        .rx_error       (rx_error),
        .fifo_ready     (fifo_ready),
`ifdef CRC16_EN
        .fifo_head_byte (fifo_head_byte),
`endif
        .fifo_r_enable  (fifo_r_enable),
        .tx_sel         (tx_sel),
        .tx_fsm_byte    (tx_fsm_byte),
        .tx_start       (tx_start),
        .tx_byte_req    (tx_byte_req),
        .tx_eop         (tx_eop),
        .tx_done        (tx_done),
        .is_txing       (is_txing)
    );

    // FIFO model: a pop retires the head byte at the end of the pop cycle.
    always @(negedge clk) begin
        if (fifo_r_enable) begin
            pop_count <= pop_count + 1;
            fifo_head <= fifo_head + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_is_txing"}, 32'(is_txing), 32'd0);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_tx_eop"}, 32'(tx_eop), 32'd0);
        chk({tag, "_fifo_r_enable"}, 32'(fifo_r_enable), 32'd0);
        chk({tag, "_tx_sel"}, 32'(tx_sel), 32'd1);
        chk({tag, "_tx_fsm_byte"}, 32'(tx_fsm_byte), 32'h80);
    endtask

    // Reference decision: which response a token deserves.
    function automatic int model_kind(input logic [7:0] pid, input logic [6:0] addr,
                                      input logic err, input logic rdy);
        if (err || addr != 7'h4C) return K_NONE;
        return (pid == 8'h69 && rdy) ? K_DATA1 : K_NAK;
    endfunction

    // USB CRC16 over the payload, bit-serial LSB first, reflected polynomial.
    function automatic logic [15:0] model_crc(input int base);
        logic [15:0] c;
        logic        b;
        c = 16'hFFFF;
        for (int i = 0; i < PKT; i++) begin
            for (int k = 0; k < 8; k++) begin
                b = fifo_mem[(base + i) % 1024][k];
                if (b ^ c[0]) c = (c >> 1) ^ 16'hA001;
                else          c = c >> 1;
            end
        end
        return c;
    endfunction

    // One IN/other token through the whole transaction, acting as receiver and transmitter.
    // rst_after >= 0 asserts reset right after that many byte requests.
    task automatic run_txn(input logic [7:0] pid, input logic [6:0] addr, input logic err,
                           input logic rdy, input int kind, input int rst_after, input bit inject);
        int          base, pops0, cyc, n, hi;
        bit          eop_seen;
        logic [7:0]  exp_q[$];
        logic [7:0]  got_q[$];
        logic [15:0] crc;
        base  = fifo_head;
        pops0 = pop_count;
        txn_no++;
        rx_pid = pid; rx_addr = addr; rx_error = err; fifo_ready = rdy; rx_token_valid = 1'b1;
        step();
        rx_token_valid = 1'b0;
        fifo_ready = ~rdy;
        if (kind == K_NONE) begin
            hi = 0;
            repeat (200) begin
                if (is_txing || tx_start) hi++;
                step();
            end
            chk("no_resp_txing", 32'(hi), 32'd0);
            chk("no_resp_pops", 32'(pop_count - pops0), 32'd0);
            $display("txn %0d pid=%h addr=%h err=%b rdy=%b kind=none bytes=0 pops=%0d",
                     txn_no, pid, addr, err, rdy, pop_count - pops0);
            return;
        end
        cyc = 1;
        while (!tx_start && cyc < 100) begin
            step();
            cyc++;
        end
        chk("tx_start_latency", 32'(cyc), 32'(TURN));
        if (!tx_start) return;
        chk("is_txing_at_start", 32'(is_txing), 32'd1);
        chk("sync_byte_at_start", 32'(tx_fsm_byte), 32'h80);

        exp_q.push_back(8'h80);
        exp_q.push_back(kind == K_DATA1 ? 8'h4B : 8'h5A);
        if (kind == K_DATA1) begin
            for (int i = 0; i < PKT; i++) exp_q.push_back(fifo_mem[(base + i) % 1024]);
`ifdef CRC16_EN
            crc = ~model_crc(base);
            exp_q.push_back(crc[7:0]);
            exp_q.push_back(crc[15:8]);
`endif
        end
        crc = 16'h0;

        n = 0;
        eop_seen = 1'b0;
        while (!eop_seen && n < 300) begin
            for (int g = $urandom_range(1, 3); g > 0; g--) begin
                if (inject && n == 20) begin
                    rx_token_valid = 1'b1; rx_pid = 8'h69; rx_addr = 7'h4C;
                    rx_error = 1'b0; fifo_ready = 1'b1; tx_done = 1'b1;
                end
                step();
                rx_token_valid = 1'b0;
                tx_done = 1'b0;
                if (tx_eop) eop_seen = 1'b1;
            end
            if (eop_seen) break;
            got_q.push_back(tx_sel ? tx_fsm_byte : fifo_head_byte);
            tx_byte_req = 1'b1;
            step();
            tx_byte_req = 1'b0;
            n++;
            if (rst_after >= 0 && n == rst_after) begin
                #2 rst = 1'b1;
                #1 chk_reset_outputs("midpkt_rst");
                step();
                step();
                rst = 1'b0;
                $display("txn %0d pid=%h addr=%h kind=%0d reset after %0d requests",
                         txn_no, pid, addr, kind, n);
                return;
            end
            eop_seen = tx_eop;
        end
        chk("eop_seen", 32'(eop_seen), 32'd1);
        chk("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("byte[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));

        hi = 0;
        repeat ($urandom_range(1, 4)) begin
            step();
            if (!is_txing) hi++;
        end
        chk("is_txing_wait_done", 32'(hi), 32'd0);
        tx_done = 1'b1;
        chk("is_txing_done_cycle", 32'(is_txing), 32'd1);
        step();
        tx_done = 1'b0;
        chk("is_txing_after_done", 32'(is_txing), 32'd0);
        chk("pop_count", 32'(pop_count - pops0), 32'(kind == K_DATA1 ? PKT : 0));
        $display("txn %0d pid=%h addr=%h err=%b rdy=%b kind=%0d bytes=%0d pops=%0d",
                 txn_no, pid, addr, err, rdy, kind, got_q.size(), pop_count - pops0);
    endtask

    typedef struct {
        logic [7:0] pid;
        logic [6:0] addr;
        logic       err;
        logic       rdy;
        int         kind;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{8'h69, 7'h4C, 1'b0, 1'b0, K_NAK};
        vecs[1] = '{8'h69, 7'h4C, 1'b0, 1'b1, K_DATA1};
        vecs[2] = '{8'h3C, 7'h4C, 1'b0, 1'b1, K_NAK};
        vecs[3] = '{8'h69, 7'h52, 1'b0, 1'b1, K_NONE};
        vecs[4] = '{8'h69, 7'h4C, 1'b0, 1'b1, K_DATA1};
        vecs[5] = '{8'h69, 7'h4C, 1'b1, 1'b1, K_NONE};
        vecs[6] = '{8'hE1, 7'h4C, 1'b0, 1'b1, K_NAK};

        for (int i = 0; i < 1024; i++) fifo_mem[i] = 8'($urandom);
        rst = 1'b1;
        rx_token_valid = 1'b0; rx_error = 1'b0; fifo_ready = 1'b0;
        tx_byte_req = 1'b0; tx_done = 1'b0; rx_pid = 8'h00; rx_addr = 7'h00;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        for (int v = 0; v < 7; v++) begin
            if (v == 1)
                for (int i = 0; i < PKT; i++) fifo_mem[(fifo_head + i) % 1024] = 8'(i);
            run_txn(vecs[v].pid, vecs[v].addr, vecs[v].err, vecs[v].rdy, vecs[v].kind, -1, 1'b0);
            step();
        end

        // Token arriving mid-payload (with a stray tx_done) must not disturb the packet.
        run_txn(8'h69, 7'h4C, 1'b0, 1'b1, K_DATA1, -1, 1'b1);
        step();
        // Reset after the tenth payload byte request, then a normal packet.
        run_txn(8'h69, 7'h4C, 1'b0, 1'b1, K_DATA1, 12, 1'b0);
        chk_reset_outputs("post_rst");
        run_txn(8'h69, 7'h4C, 1'b0, 1'b1, K_DATA1, -1, 1'b0);
        step();

        for (int r = 0; r < 30; r++) begin
            logic [7:0] pid;
            logic [6:0] addr;
            logic       err, rdy;
            case ($urandom_range(0, 3))
                0, 1:    pid = 8'h69;
                2:       pid = 8'hE1;
                default: pid = 8'($urandom);
            endcase
            addr = ($urandom_range(0, 3) != 0) ? 7'h4C : 7'($urandom);
            err  = ($urandom_range(0, 7) == 0);
            rdy  = 1'($urandom);
            run_txn(pid, addr, err, rdy, model_kind(pid, addr, err, rdy), -1, 1'b0);
            repeat ($urandom_range(1, 3)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
